// File: rtl/shared_dmem_arbiter_if.sv
// Per-core load/store request bundle shared between the cores and the
// shared data memory. Each field is a flat concatenation, core i occupying
// slice i of every vector.
interface shared_dmem_arbiter_if #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CORES-1:0]                  req;
    logic [NUM_CORES-1:0]                  write;
    logic [NUM_CORES*32-1:0]               addr;
    logic [NUM_CORES*DATA_WIDTH-1:0]       write_data;
    logic [NUM_CORES*(DATA_WIDTH/8)-1:0]   byte_en;
    logic [NUM_CORES-1:0]                  gnt;
    logic [NUM_CORES-1:0]                  rvalid;
    logic [NUM_CORES*DATA_WIDTH-1:0]       read_data;

    // Core side: issues requests, receives grant and load data
    modport master (
        output req, write, addr, write_data, byte_en,
        input  gnt, rvalid, read_data
    );

    // Memory side: arbitrates and serves one access per cycle
    modport slave (
        input  req, write, addr, write_data, byte_en,
        output gnt, rvalid, read_data
    );
endinterface

// File: rtl/shared_dmem_arbiter.sv
// Shared data memory for several cores: a round-robin arbiter picks at most
// one request per cycle and performs it on a word-addressed, byte-masked RAM.
// Load data returns one cycle after the grant; ungranted cores stall by
// holding their request.
module shared_dmem_arbiter #(
    parameter int NUM_CORES  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    shared_dmem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    logic [PTR_W-1:0]       ptr_reg;
    logic [PTR_W-1:0]       ptr_next;
    logic [2*NUM_CORES-1:0] req_dbl;
    logic [NUM_CORES-1:0]   grant;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   gnt_any;
    int                     offs;
    int                     win;

    logic [AW-1:0]          sel_idx;
    logic [DATA_WIDTH-1:0]  sel_wdata;
    logic [BE_W-1:0]        sel_be;
    logic                   sel_write;
    logic                   store_en;
    logic                   load_en;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic [NUM_CORES-1:0]   rvalid_reg;

    // Round-robin search: rotate requests so the pointer's core sits at bit 0,
    // take the first set bit, then rotate the winner back to a core number.
    // Depends only on req and ptr so the grant path never sees address/data.
    always_comb begin
        req_dbl = {bus.req, bus.req} >> ptr_reg;
        gnt_any = 1'b0;
        offs    = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (!gnt_any && req_dbl[k]) begin
                gnt_any = 1'b1;
                offs    = k;
            end
        end
        win = int'(ptr_reg) + offs;
        if (win >= NUM_CORES) begin
            win = win - NUM_CORES;
        end
        gnt_idx = PTR_W'(win);
        grant   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            grant[i] = gnt_any && (win == i);
        end
    end

    // Steer the granted core's address, data, mask and direction to the RAM
    always_comb begin
        sel_idx   = '0;
        sel_wdata = '0;
        sel_be    = '0;
        sel_write = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (grant[i]) begin
                sel_idx   = bus.addr[32*i+2 +: AW];
                sel_wdata = bus.write_data[DATA_WIDTH*i +: DATA_WIDTH];
                sel_be    = bus.byte_en[BE_W*i +: BE_W];
                sel_write = bus.write[i];
            end
        end
    end

    // A reset cycle still shows a grant but must not touch any state
    assign store_en = reset && gnt_any && sel_write;
    assign load_en  = reset && gnt_any && !sel_write;

    // Pointer moves just past the winner; idle cycles leave it alone
    always_comb begin
        ptr_next = ptr_reg;
        if (gnt_any) begin
            ptr_next = (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Arbiter pointer and one-cycle load-valid pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_reg    <= '0;
            rvalid_reg <= '0;
        end else begin
            ptr_reg    <= ptr_next;
            rvalid_reg <= grant & {NUM_CORES{load_en}};
        end
    end

    // One 8-bit RAM per byte lane so each mask bit is a plain write enable.
    // Contents are deliberately not cleared by reset.
    generate
        for (genvar gi = 0; gi < BE_W; gi++) begin : lane_g
            logic [7:0] mem [DEPTH];

            // Masked byte write at the edge of a granted store
            always_ff @(posedge clk) begin
                if (store_en && sel_be[gi]) begin
                    mem[sel_idx] <= sel_wdata[8*gi +: 8];
                end
            end

            assign rd_word[8*gi +: 8] = mem[sel_idx];
        end
    endgenerate

    // Per-core load data register: captures on its own load grant, else holds
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : core_g
            logic [DATA_WIDTH-1:0] data_reg;

            // Capture RAM word for this core's granted load
            always_ff @(posedge clk) begin
                if (!reset) begin
                    data_reg <= '0;
                end else if (load_en && grant[gi]) begin
                    data_reg <= rd_word;
                end
            end

            assign bus.read_data[DATA_WIDTH*gi +: DATA_WIDTH] = data_reg;
        end
    endgenerate

    assign bus.gnt    = grant;
    assign bus.rvalid = rvalid_reg;
endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Bench for shared_dmem_arbiter with two cores: a vector table drives one
// cycle per record, a small memory model predicts load data into a queue,
// and the queue is drained when rvalid is due.
module tb_shared_dmem_arbiter;
    localparam int NC    = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    shared_dmem_arbiter_if #(.NUM_CORES(NC), .DATA_WIDTH(DW)) bus ();

    shared_dmem_arbiter #(.NUM_CORES(NC), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [1:0]  exp_gnt;
    } vec_t;

    typedef struct {
        int          core;
        logic [31:0] data;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [31:0] exp_rd [NC];
    int          tests_run = 0;
    int          tests_failed = 0;

    function automatic vec_t mk(string n, logic r, logic [1:0] rq, logic [1:0] wr,
                                logic [31:0] a0, logic [31:0] a1,
                                logic [31:0] d0, logic [31:0] d1,
                                logic [3:0] be0, logic [3:0] be1, logic [1:0] eg);
        vec_t v;
        v.name = n; v.rst_n = r; v.req = rq; v.wr = wr;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.be0 = be0; v.be1 = be1; v.exp_gnt = eg;
        return v;
    endfunction

    task automatic check(string n, logic [31:0] act, logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", n, act, exp);
        end
    endtask

    // One cycle: drive, check grant, update model, clock, check load return
    task automatic apply(input vec_t v, output logic [1:0] gnt_seen);
        logic        g;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic [5:0]  idx;
        logic [1:0]  exp_rv;
        exp_t        e;

        reset          = v.rst_n;
        bus.req        = v.req;
        bus.write      = v.wr;
        bus.addr       = {v.a1, v.a0};
        bus.write_data = {v.d1, v.d0};
        bus.byte_en    = {v.be1, v.be0};
        #2;
        gnt_seen = bus.gnt;
        check({v.name, ".gnt"}, 32'(bus.gnt), 32'(v.exp_gnt));

        if (v.rst_n && v.exp_gnt != 2'b00) begin
            g   = v.exp_gnt[1];
            a   = g ? v.a1 : v.a0;
            d   = g ? v.d1 : v.d0;
            be  = g ? v.be1 : v.be0;
            idx = a[7:2];
            if (v.wr[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mdl_mem[idx][8*b +: 8] = d[8*b +: 8];
                end
            end else begin
                e.core = int'(g);
                e.data = mdl_mem[idx];
                sb.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        exp_rv = 2'b00;
        if (!v.rst_n) begin
            for (int c = 0; c < NC; c++) exp_rd[c] = '0;
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_rd[e.core] = e.data;
            exp_rv = 2'b01 << e.core;
        end
        check({v.name, ".rvalid"}, 32'(bus.rvalid), 32'(exp_rv));
        check({v.name, ".rd0"}, bus.read_data[31:0], exp_rd[0]);
        check({v.name, ".rd1"}, bus.read_data[63:32], exp_rd[1]);
        $display("[TB] %-10s rst_n=%b req=%b wr=%b gnt=%b rvalid=%b rd0=%08h rd1=%08h",
                 v.name, v.rst_n, v.req, v.wr, gnt_seen, bus.rvalid,
                 bus.read_data[31:0], bus.read_data[63:32]);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] gs;
        int         cnt0;
        int         cnt1;
        int         waited;
        logic       seen;

        for (int c = 0; c < NC; c++) exp_rd[c] = '0;
        bus.req = '0; bus.write = '0; bus.addr = '0;
        bus.write_data = '0; bus.byte_en = '0;

        //                 name        rst req    wr     a0        a1        d0            d1            be0    be1    gnt
        vecs.push_back(mk("rst0",      0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("rst_gnt",   0, 2'b01, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("st_dead",   1, 2'b01, 2'b01, 32'h10,   32'h0,    32'hDEADBEEF, 32'h0,        4'hF,  4'h0,  2'b01));
        vecs.push_back(mk("ld_dead",   1, 2'b01, 2'b00, 32'h10,   32'h0,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("st_aa",     1, 2'b01, 2'b01, 32'h10,   32'h0,    32'h000000AA, 32'h0,        4'h1,  4'h0,  2'b01));
        vecs.push_back(mk("ld_aa",     1, 2'b01, 2'b00, 32'h10,   32'h0,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("st_alias",  1, 2'b10, 2'b10, 32'h0,    32'h104,  32'h0,        32'h12345678, 4'h0,  4'hF,  2'b10));
        vecs.push_back(mk("ld_alias",  1, 2'b10, 2'b00, 32'h0,    32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("rst1",      0, 2'b00, 2'b00, 32'h0,    32'h0,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("cont0",     1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("cont1",     1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("cont2",     1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("cont3",     1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("pre_idle",  1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("idle0",     1, 2'b00, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("idle1",     1, 2'b00, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("idle2",     1, 2'b00, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("post_idle", 1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("ld_c1",     1, 2'b10, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("rst_st",    0, 2'b01, 2'b01, 32'h10,   32'h4,    32'h11111111, 32'h0,        4'hF,  4'h0,  2'b01));
        vecs.push_back(mk("after_rst", 1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("ld_c0b",    1, 2'b01, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("rst2",      0, 2'b00, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b00));
        vecs.push_back(mk("ptr_rst",   1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("st_be0",    1, 2'b10, 2'b10, 32'h10,   32'h4,    32'h0,        32'hFFFFFFFF, 4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("after_be0", 1, 2'b11, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b01));
        vecs.push_back(mk("ld_be0",    1, 2'b10, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));
        vecs.push_back(mk("st_mid",    1, 2'b10, 2'b10, 32'h10,   32'h4,    32'h0,        32'h00AB0000, 4'h0,  4'h4,  2'b10));
        vecs.push_back(mk("ld_mid",    1, 2'b10, 2'b00, 32'h10,   32'h4,    32'h0,        32'h0,        4'h0,  4'h0,  2'b10));

        foreach (vecs[i]) begin
            apply(vecs[i], gs);
        end

        // Fairness: after reset, both cores held for 4 cycles get two grants each
        apply(mk("rst3", 0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00), gs);
        cnt0 = 0;
        cnt1 = 0;
        for (int k = 0; k < 4; k++) begin
            apply(mk("fair", 1, 2'b11, 2'b00, 32'h10, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0,
                     (k % 2 == 0) ? 2'b01 : 2'b10), gs);
            cnt0 += int'(gs[0]);
            cnt1 += int'(gs[1]);
        end
        check("fair.core0_grants", 32'(cnt0), 32'd2);
        check("fair.core1_grants", 32'(cnt1), 32'd2);

        // Bounded stall: core1 competes with core0 using empty-mask stores,
        // and must be served within NUM_CORES-1 cycles of waiting
        apply(mk("rst4", 0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 4'h0, 4'h0, 2'b00), gs);
        reset          = 1'b1;
        bus.req        = 2'b11;
        bus.write      = 2'b11;
        bus.byte_en    = '0;
        bus.write_data = {32'hFFFFFFFF, 32'hFFFFFFFF};
        waited = 0;
        seen   = 1'b0;
        for (int c = 0; c < NC + 1 && !seen; c++) begin
            #2;
            if (bus.gnt[1]) seen = 1'b1;
            else waited++;
            @(posedge clk);
            #1;
            $display("[TB] stall      cycle=%0d gnt1=%b rvalid=%b", c, seen, bus.rvalid);
        end
        check("stall.core1_served", 32'(seen), 32'd1);
        check("stall.wait_cycles", 32'(waited), 32'd1);
        check("stall.rvalid", 32'(bus.rvalid), 32'd0);
        bus.req = 2'b00;

        // RAM untouched by the empty-mask stores
        apply(mk("ld_final", 1, 2'b01, 2'b00, 32'h10, 32'h4, 32'h0, 32'h0, 4'h0, 4'h0, 2'b01), gs);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/shared_dmem_arbiter.md
# shared_dmem_arbiter

Shared data memory for a multi-core RISC-V system: NUM_CORES cores each present a load/store request, a round-robin arbiter grants at most one per cycle, and the granted access is performed on an internal word-addressed RAM. Writes are byte-masked and commit at the clock edge. Read data returns one cycle after grant. This block replaces the single-port data memory when the top level instantiates more than one core; ungranted cores must stall.

## Interface
- NUM_CORES, 2, number of requesting cores (1..8)
- DATA_WIDTH, 32, word width in bits (multiple of 8)
- DEPTH, 64, RAM depth in words (power of 2)
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset; reset is sampled only on the rising edge of clk
- req  input  NUM_CORES  per-core access request
- write  input  NUM_CORES  per-core 1 = store, 0 = load (valid with req)
- addr  input  NUM_CORES*32  per-core byte address, core i at [32*i +: 32]
- write_data  input  NUM_CORES*DATA_WIDTH  per-core store data
- byte_en  input  NUM_CORES*(DATA_WIDTH/8)  per-core store byte mask
- gnt  output  NUM_CORES  combinational one-hot grant for this cycle
- rvalid  output  NUM_CORES  registered pulse, load data valid for core i
- read_data  output  NUM_CORES*DATA_WIDTH  registered per-core load data

## Operation
- Word index = addr[2 +: log2(DEPTH)]; upper address bits ignored (aliasing wrap-around).
- Arbiter: round-robin pointer ptr (log2 NUM_CORES bits, min 1). Grant goes to the first i with req[i]=1, searching ptr, ptr+1, ... mod NUM_CORES. No req means gnt = 0 and ptr is unchanged.
- After any grant to core g, ptr <= (g+1) mod NUM_CORES.
- Granted store: for every set byte_en bit b, RAM[idx] byte b <= write_data byte b at the edge. byte_en = 0 means no change; the access is still granted and ptr still advances.
- Granted load: at the edge, read_data[g] <= RAM[idx], rvalid[g] <= 1. All other rvalid bits <= 0. The read_data of non-granted cores holds its last value.
- Read after write: a load granted the cycle after a store to the same word returns the new data.
- gnt depends only on req and ptr (no combinational path from addr/data).
- Ungranted requesters keep req asserted. The block holds no request queue.

## Timing
- Reset (reset=0 at edge): ptr <= 0, rvalid <= 0, read_data <= 0 for all cores. RAM contents are not cleared. Any store presented in a reset cycle is suppressed. gnt remains combinational during reset, but no state changes.
- Reset asserted the cycle after a load grant: rvalid is cleared and the pending pulse is lost.
- Latency: grant in cycle 0 (same cycle as req). Store visible in RAM after edge 0. Load data and rvalid in cycle 1, for exactly one cycle.
- Throughput: one access per cycle total. Worst-case wait for any core is NUM_CORES-1 cycles while it keeps req high.
- NUM_CORES=1: ptr is constant 0 and gnt = req.

## Test plan
- Reset, then core0 stores 0xDEADBEEF to 0x10 with byte_en=0xF, then loads 0x10 -> gnt[0]=1 in both cycles; rvalid[0]=1 one cycle after the load with read_data[0]=0xDEADBEEF.
- Byte mask: RAM word 0x10 = 0xDEADBEEF; store 0x000000AA with byte_en=0x1, then load -> 0xDEADBEAA.
- Contention with NUM_CORES=2: both cores hold req for 4 cycles after reset -> gnt sequence 01,10,01,10 (core0 first since ptr=0); each core is granted exactly twice.
- Aliasing with DEPTH=64: store 0x12345678 to 0x00000104, load 0x00000004 -> 0x12345678.
- Reset during traffic: core1 load granted in cycle n with reset=0 at edge n+1 -> rvalid all 0 and read_data all 0 after edge n+1; ptr=0, so the next contended grant goes to core0. A store issued in the reset cycle leaves RAM unchanged.
- Idle cycles: req=0 for 3 cycles between grants -> gnt=0 and rvalid=0 during them; ptr is unchanged, verified by the next contended grant order.
